// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - two-requester arbiter for a single-port data RAM
//
// Arbitrates one RAM port between a CPU (read/write) and a video fetcher
// (read-only). Grants are combinational; read data returns one cycle after
// the grant and is steered by a registered owner tag.
//
// Optional feature: define DMEM_ARB_STARVE_GUARD_EN to enable the video
// starvation guard. This forces a video grant after STARVE_MAX consecutive
// denied video-request cycles. Without it, the CPU has strict priority.
//
// Ports:
//   clock, reset               - single clock, synchronous active-high reset
//   cpu_req/we/addr/wdata      - CPU request
//   cpu_gnt, cpu_stall         - CPU accepted / CPU held off this cycle
//   cpu_rdata, cpu_rvalid      - CPU read response
//   vid_req, vid_addr          - video read request
//   vid_gnt                    - video accepted this cycle
//   vid_rdata, vid_rvalid      - video read response
//   mem_wEn, mem_addr,
//   mem_dataIn, mem_dataOut    - RAM port (read data registered, 1-cycle latency)
module dmem_arbiter #(
  parameter int ADDR_W     = 12,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_stall,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_rvalid,
  input  logic              vid_req,
  input  logic [ADDR_W-1:0] vid_addr,
  output logic              vid_gnt,
  output logic [DATA_W-1:0] vid_rdata,
  output logic              vid_rvalid,
  output logic              mem_wEn,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_dataIn,
  input  logic [DATA_W-1:0] mem_dataOut
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CPU_RD = 2'd1,
    VID_RD = 2'd2
  } state_t;

  state_t            state_q;
  state_t            state_d;
  logic [ADDR_W-1:0] addr_q;
  logic              vid_prio;

  if (STARVE_MAX < 1) begin : g_bad_starve_max
    $error("STARVE_MAX must be at least 1");
  end

`ifdef DMEM_ARB_STARVE_GUARD_EN
  localparam int CNT_W = $clog2(STARVE_MAX + 1);

  logic [CNT_W-1:0] starve_cnt;

  // Video overrides the CPU only once it has been refused STARVE_MAX times.
  assign vid_prio = (starve_cnt == CNT_W'(STARVE_MAX));

  always_ff @(posedge clock) begin
    if (reset) begin
      starve_cnt <= '0;
    end else if (vid_gnt) begin
      starve_cnt <= '0;
    end else if (vid_req && !vid_prio) begin
      starve_cnt <= starve_cnt + 1'b1;
    end
  end
`else
  assign vid_prio = 1'b0;
`endif

  // Grant selection and next owner tag. Grants are suppressed during reset
  // so no access (and hence no read response) can start while it is held.
  always_comb begin
    cpu_gnt = 1'b0;
    vid_gnt = 1'b0;
    state_d = IDLE;
    if (!reset) begin
      if (cpu_req && !(vid_req && vid_prio)) begin
        cpu_gnt = 1'b1;
      end else if (vid_req) begin
        vid_gnt = 1'b1;
      end
    end
    if (cpu_gnt && !cpu_we) begin
      state_d = CPU_RD;
    end else if (vid_gnt) begin
      state_d = VID_RD;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= mem_addr;
    end
  end

  // With no grant the RAM address holds, avoiding needless address toggles.
  assign mem_addr   = cpu_gnt ? cpu_addr : (vid_gnt ? vid_addr : addr_q);
  assign mem_wEn    = cpu_gnt & cpu_we;
  assign mem_dataIn = cpu_wdata;
  assign cpu_stall  = cpu_req & ~cpu_gnt;

  // Both consumers see the RAM output; only the strobes are steered.
  assign cpu_rdata  = mem_dataOut;
  assign vid_rdata  = mem_dataOut;
  assign cpu_rvalid = (state_q == CPU_RD);
  assign vid_rvalid = (state_q == VID_RD);

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - table-driven testbench for dmem_arbiter
module tb_dmem_arbiter;

  localparam int ADDR_W = 12;
  localparam int DATA_W = 32;

`ifdef DMEM_ARB_STARVE_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  logic              clock = 1'b0;
  logic              reset;
  logic              cpu_req, cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic              cpu_gnt, cpu_stall, cpu_rvalid;
  logic [DATA_W-1:0] cpu_rdata;
  logic              vid_req;
  logic [ADDR_W-1:0] vid_addr;
  logic              vid_gnt, vid_rvalid;
  logic [DATA_W-1:0] vid_rdata;
  logic              mem_wEn;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_dataIn;
  logic [DATA_W-1:0] mem_dataOut;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  dmem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_MAX(4)) dut (
    .clock(clock), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt), .cpu_stall(cpu_stall), .cpu_rdata(cpu_rdata), .cpu_rvalid(cpu_rvalid),
    .vid_req(vid_req), .vid_addr(vid_addr), .vid_gnt(vid_gnt),
    .vid_rdata(vid_rdata), .vid_rvalid(vid_rvalid),
    .mem_wEn(mem_wEn), .mem_addr(mem_addr), .mem_dataIn(mem_dataIn), .mem_dataOut(mem_dataOut)
  );

  // RAM with registered read data (old data on read-during-write).
  logic [DATA_W-1:0] ram [0:(1<<ADDR_W)-1];
  always @(posedge clock) begin
    if (mem_wEn) ram[mem_addr] <= mem_dataIn;
    mem_dataOut <= ram[mem_addr];
  end

  typedef struct {
    logic              rst;
    logic              creq;
    logic              cwe;
    logic [ADDR_W-1:0] caddr;
    logic [DATA_W-1:0] cwdata;
    logic              vreq;
    logic [ADDR_W-1:0] vaddr;
    logic              e_cgnt;
    logic              e_vgnt;
    logic              e_stall;
    logic              e_wen;
    logic [ADDR_W-1:0] e_addr;
    logic              e_crv;
    logic              e_vrv;
    logic [DATA_W-1:0] e_rdata;
  } vec_t;

  localparam int NV = 15;
  vec_t vec [NV];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic set_vec(input int i, input logic rst, input logic creq, input logic cwe,
                         input logic [ADDR_W-1:0] caddr, input logic [DATA_W-1:0] cwdata,
                         input logic vreq, input logic [ADDR_W-1:0] vaddr,
                         input logic ecg, input logic evg, input logic est, input logic ewe,
                         input logic [ADDR_W-1:0] eaddr, input logic ecrv, input logic evrv,
                         input logic [DATA_W-1:0] erd);
    vec[i] = '{rst, creq, cwe, caddr, cwdata, vreq, vaddr, ecg, evg, est, ewe, eaddr, ecrv, evrv, erd};
  endtask

  task automatic drive(input logic rst, input logic creq, input logic cwe,
                       input logic [ADDR_W-1:0] caddr, input logic [DATA_W-1:0] cwdata,
                       input logic vreq, input logic [ADDR_W-1:0] vaddr);
    @(posedge clock);
    #1;
    reset = rst; cpu_req = creq; cpu_we = cwe; cpu_addr = caddr; cpu_wdata = cwdata;
    vid_req = vreq; vid_addr = vaddr;
    @(negedge clock);
  endtask

  initial begin
    for (int a = 0; a < (1 << ADDR_W); a++) ram[a] = '0;
    ram[12'h001] = 32'h1111_1111;
    ram[12'h002] = 32'h2222_2222;
    ram[12'h003] = 32'h3333_3333;
    ram[12'h020] = 32'h2020_2020;

    //          rst creq we caddr   cwdata        vreq vaddr   cg vg st we addr    crv vrv rdata
    set_vec( 0, 1,  1,  0, 12'h07F, 32'h0,        1,  12'h07E, 0, 0, 1, 0, 12'h000, 0, 0, 32'h0);
    set_vec( 1, 0,  1,  1, 12'h010, 32'hDEADBEEF, 0,  12'h000, 1, 0, 0, 1, 12'h010, 0, 0, 32'h0);
    set_vec( 2, 0,  1,  0, 12'h010, 32'h0,        0,  12'h000, 1, 0, 0, 0, 12'h010, 0, 0, 32'h0);
    set_vec( 3, 0,  0,  0, 12'h000, 32'h0,        0,  12'h000, 0, 0, 0, 0, 12'h010, 1, 0, 32'hDEADBEEF);
    set_vec( 4, 0,  0,  0, 12'h000, 32'h0,        1,  12'h020, 0, 1, 0, 0, 12'h020, 0, 0, 32'h0);
    set_vec( 5, 0,  0,  0, 12'h000, 32'h0,        0,  12'h000, 0, 0, 0, 0, 12'h020, 0, 1, 32'h2020_2020);
    set_vec( 6, 0,  1,  0, 12'h001, 32'h0,        0,  12'h000, 1, 0, 0, 0, 12'h001, 0, 0, 32'h0);
    set_vec( 7, 0,  0,  0, 12'h000, 32'h0,        1,  12'h002, 0, 1, 0, 0, 12'h002, 1, 0, 32'h1111_1111);
    set_vec( 8, 0,  1,  0, 12'h001, 32'h0,        0,  12'h000, 1, 0, 0, 0, 12'h001, 0, 1, 32'h2222_2222);
    set_vec( 9, 0,  0,  0, 12'h000, 32'h0,        1,  12'h002, 0, 1, 0, 0, 12'h002, 1, 0, 32'h1111_1111);
    set_vec(10, 0,  0,  0, 12'h000, 32'h0,        0,  12'h000, 0, 0, 0, 0, 12'h002, 0, 1, 32'h2222_2222);
    set_vec(11, 0,  1,  0, 12'h003, 32'h0,        1,  12'h004, 1, 0, 0, 0, 12'h003, 0, 0, 32'h0);
    set_vec(12, 0,  0,  0, 12'h000, 32'h0,        0,  12'h000, 0, 0, 0, 0, 12'h003, 1, 0, 32'h3333_3333);
    set_vec(13, 0,  1,  1, 12'h005, 32'hA5A5A5A5, 1,  12'h006, 1, 0, 0, 1, 12'h005, 0, 0, 32'h0);
    set_vec(14, 0,  0,  0, 12'h000, 32'h0,        0,  12'h000, 0, 0, 0, 0, 12'h005, 0, 0, 32'h0);

    reset = 1'b1; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    vid_req = 1'b0; vid_addr = '0;
    repeat (2) @(posedge clock);

    for (int i = 0; i < NV; i++) begin
      drive(vec[i].rst, vec[i].creq, vec[i].cwe, vec[i].caddr, vec[i].cwdata, vec[i].vreq, vec[i].vaddr);
      check($sformatf("v%0d cpu_gnt", i),    64'(cpu_gnt),    64'(vec[i].e_cgnt));
      check($sformatf("v%0d vid_gnt", i),    64'(vid_gnt),    64'(vec[i].e_vgnt));
      check($sformatf("v%0d cpu_stall", i),  64'(cpu_stall),  64'(vec[i].e_stall));
      check($sformatf("v%0d mem_wEn", i),    64'(mem_wEn),    64'(vec[i].e_wen));
      check($sformatf("v%0d mem_addr", i),   64'(mem_addr),   64'(vec[i].e_addr));
      check($sformatf("v%0d cpu_rvalid", i), 64'(cpu_rvalid), 64'(vec[i].e_crv));
      check($sformatf("v%0d vid_rvalid", i), 64'(vid_rvalid), 64'(vec[i].e_vrv));
      if (vec[i].e_crv) check($sformatf("v%0d cpu_rdata", i), 64'(cpu_rdata), 64'(vec[i].e_rdata));
      if (vec[i].e_vrv) check($sformatf("v%0d vid_rdata", i), 64'(vid_rdata), 64'(vec[i].e_rdata));
      if (vec[i].e_wen) check($sformatf("v%0d mem_dataIn", i), 64'(mem_dataIn), 64'(vec[i].cwdata));
    end

    // Build up video denials, then reset in the cycle of a video request.
    for (int c = 0; c < 2; c++) begin
      drive(1'b0, 1'b1, 1'b0, 12'h001, 32'h0, 1'b1, 12'h002);
      check($sformatf("pre c%0d cpu_gnt", c), 64'(cpu_gnt), 64'd1);
    end
    drive(1'b1, 1'b0, 1'b0, 12'h000, 32'h0, 1'b1, 12'h020);
    check("rst vid_gnt", 64'(vid_gnt), 64'd0);
    check("rst mem_wEn", 64'(mem_wEn), 64'd0);
    drive(1'b0, 1'b0, 1'b0, 12'h000, 32'h0, 1'b0, 12'h000);
    check("post-rst vid_rvalid", 64'(vid_rvalid), 64'd0);
    check("post-rst cpu_rvalid", 64'(cpu_rvalid), 64'd0);
    check("post-rst mem_addr", 64'(mem_addr), 64'd0);

    // Both requests held for six cycles; the counter must start from zero.
    for (int c = 0; c < 6; c++) begin
      logic ev;
      ev = GUARD && (c == 4);
      drive(1'b0, 1'b1, 1'b0, 12'h001, 32'h0, 1'b1, 12'h002);
      check($sformatf("starve c%0d cpu_gnt", c),   64'(cpu_gnt),   64'(!ev));
      check($sformatf("starve c%0d vid_gnt", c),   64'(vid_gnt),   64'(ev));
      check($sformatf("starve c%0d cpu_stall", c), 64'(cpu_stall), 64'(ev));
      check($sformatf("starve c%0d mem_addr", c),  64'(mem_addr),  ev ? 64'h002 : 64'h001);
      if (c == 5) check("starve c5 vid_rvalid", 64'(vid_rvalid), 64'(GUARD));
    end
    drive(1'b0, 1'b0, 1'b0, 12'h000, 32'h0, 1'b0, 12'h000);
    check("starve tail cpu_rvalid", 64'(cpu_rvalid), 64'd1);
    check("starve tail cpu_rdata", 64'(cpu_rdata), 64'h1111_1111);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
